// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux: one-hot registered grant/select,
// per-owner hold limit, and a registered mux output that trails the grant by one cycle.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   d_in,
    output logic [3:0]            grant,
    output logic [1:0]            sel,
    output logic                  busy,
    output logic [DATA_W-1:0]     y,
    output logic                  y_valid
);

    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                y_valid_q, y_valid_d;

    logic [DATA_W-1:0]   d_slice [4];
    logic [1:0]          cand_idx [4];
    logic [3:0]          req_rot;
    logic                win_found;
    logic [1:0]          win_idx;
    logic                hold_last;
    logic                rearb;
    logic                busy_w;

    // req_rot[k] is the request k positions after ptr, so bit 0 has top priority.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign d_slice[gi]  = d_in[gi*DATA_W +: DATA_W];
        assign cand_idx[gi] = ptr_q + 2'(gi);
        assign req_rot[gi]  = req[cand_idx[gi]];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    assign busy_w    = |grant_q;
    assign hold_last = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
    assign rearb     = (state_q == IDLE) || !req[sel_q] || hold_last;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        if (rearb) begin
            // The outgoing owner sits at the bottom of the rotated order, so it
            // only wins back the mux when nobody else is asking.
            hold_cnt_d = '0;
            if (win_found) begin
                state_d = OWN;
                grant_d = 4'b0001 << win_idx;
                sel_d   = win_idx;
                ptr_d   = win_idx + 2'd1;
            end else begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        end else if (!hold_last) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
    end

    always_comb begin
        y_d       = busy_w ? d_slice[sel_q] : '0;
        y_valid_d = busy_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_w;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, solo owner, handover,
// hold-limit re-grant and asynchronous reset mid-grant, all against hand-computed values.
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 4;
    localparam int MAX_HOLD = 8;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           req;
    logic [4*DATA_W-1:0]  d_in;
    logic [3:0]           grant;
    logic [1:0]           sel;
    logic                 busy;
    logic [DATA_W-1:0]    y;
    logic                 y_valid;

    int checks;
    int errors;

    logic [3:0] dv [4];

    mux4_rr_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d_in    (d_in),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic [3:0] yy, input logic yv);
        check({tag, ".grant"},   32'(grant),   32'(g));
        check({tag, ".busy"},    32'(busy),    32'(|g));
        check({tag, ".sel"},     32'(sel),     32'(s));
        check({tag, ".y"},       32'(y),       32'(yy));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(yv));
        $display("%s: req=%b grant=%b sel=%0d busy=%b y=%h y_valid=%b",
                 tag, req, grant, sel, busy, y, y_valid);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int owner;
        logic [3:0] exp_y;

        checks = 0;
        errors = 0;
        dv[0] = 4'hA;
        dv[1] = 4'hB;
        dv[2] = 4'hC;
        dv[3] = 4'hD;
        d_in  = {dv[3], dv[2], dv[1], dv[0]};
        rst_n = 1'b0;
        req   = 4'b1111;

        #1 outs("rst_async", 4'b0000, 2'd0, 4'h0, 1'b0);
        step();
        outs("rst_held0", 4'b0000, 2'd0, 4'h0, 1'b0);
        step();
        outs("rst_held1", 4'b0000, 2'd0, 4'h0, 1'b0);
        rst_n = 1'b1;

        // All four requesting: 8 cycles each, in order 0,1,2,3, no gaps.
        for (int c = 0; c < 32; c++) begin
            step();
            owner = (c / MAX_HOLD) % 4;
            exp_y = (c == 0) ? 4'h0 : dv[((c - 1) / MAX_HOLD) % 4];
            outs($sformatf("rot%0d", c), 4'(1 << owner), 2'(owner), exp_y, c != 0);
        end
        req = 4'b0000;
        step();
        outs("rot_idle0", 4'b0000, 2'd3, dv[3], 1'b1);
        step();
        outs("rot_idle1", 4'b0000, 2'd3, 4'h0, 1'b0);

        // Requester 2 alone for three cycles.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            outs($sformatf("solo2_%0d", i), 4'b0100, 2'd2, (i == 0) ? 4'h0 : dv[2], i != 0);
        end
        req = 4'b0000;
        step();
        outs("solo2_rel0", 4'b0000, 2'd2, dv[2], 1'b1);
        step();
        outs("solo2_rel1", 4'b0000, 2'd2, 4'h0, 1'b0);

        // Requester 1 owns; requester 3 waits without preempting, then takes over on drop.
        req = 4'b0010;
        step();
        outs("hand_h0", 4'b0010, 2'd1, 4'h0, 1'b0);
        step();
        outs("hand_h1", 4'b0010, 2'd1, dv[1], 1'b1);
        req = 4'b1010;
        for (int i = 2; i < 5; i++) begin
            step();
            outs($sformatf("hand_h%0d", i), 4'b0010, 2'd1, dv[1], 1'b1);
        end
        req = 4'b1000;
        step();
        outs("hand_sw0", 4'b1000, 2'd3, dv[1], 1'b1);
        step();
        outs("hand_sw1", 4'b1000, 2'd3, dv[3], 1'b1);
        req = 4'b0000;
        step();
        outs("hand_idle0", 4'b0000, 2'd3, dv[3], 1'b1);
        step();
        outs("hand_idle1", 4'b0000, 2'd3, 4'h0, 1'b0);

        // Lone requester 0 is re-granted at each hold limit without dropping busy.
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            outs($sformatf("solo0_%0d", i), 4'b0001, 2'd0, (i == 0) ? 4'h0 : dv[0], i != 0);
        end
        req = 4'b0000;
        step();
        outs("solo0_rel0", 4'b0000, 2'd0, dv[0], 1'b1);
        step();
        outs("solo0_rel1", 4'b0000, 2'd0, 4'h0, 1'b0);

        // Asynchronous reset while requester 2 owns; ptr must return to 0.
        req = 4'b0100;
        step();
        outs("mid_g0", 4'b0100, 2'd2, 4'h0, 1'b0);
        step();
        outs("mid_g1", 4'b0100, 2'd2, dv[2], 1'b1);
        #2 rst_n = 1'b0;
        #1 outs("mid_rst", 4'b0000, 2'd0, 4'h0, 1'b0);
        req = 4'b1111;
        #2 rst_n = 1'b1;
        step();
        outs("post_rst0", 4'b0001, 2'd0, 4'h0, 1'b0);
        step();
        outs("post_rst1", 4'b0001, 2'd0, dv[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters.
- Each requester raises req to own the mux. The block grants one requester at a time, drives the mux select, and registers the selected data word.
- A hold limit stops any single requester from monopolising the shared output.
- Sits in front of the shared 4:1 mux / downstream consumer.

Parameters:
- DATA_W, 1: width of each data input and of y.
- MAX_HOLD, 8: maximum consecutive cycles one grant lasts (>=1). Hold-counter width is clog2(MAX_HOLD+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit k = requester k.
- d_in  input  4*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- grant  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  mux select = index of the granted requester, registered.
- busy  output  1  high while any grant is active.
- y  output  DATA_W  registered mux output.
- y_valid  output  1  high when y holds data from a granted requester.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously on clk):
  - grant=0, sel=0, busy=0, y=0, y_valid=0, hold_cnt=0, state=IDLE.
  - Round-robin pointer ptr=0, so requester 0 has top priority first.
- States:
  - IDLE: no grant.
  - OWN: grant[sel]=1.
- Arbitration (evaluated at a clk edge when state=IDLE, or when OWN releases):
  - Search req starting at index ptr, ascending modulo 4. The first set bit wins.
  - The winner's grant and sel are registered at that edge. Grant appears the cycle after req is sampled (1-cycle latency).
  - ptr becomes winner+1 (mod 4), so the previous owner has lowest priority next time.
- IDLE -> OWN: any req bit high at the edge; hold_cnt=0.
- OWN release conditions, checked at each edge:
  - (a) req[sel]=0, or
  - (b) hold_cnt==MAX_HOLD-1 with req[sel] still high (forced rotation).
- On release, re-arbitrate at the same edge (zero idle cycles):
  - If another request is pending, its grant replaces the old one directly.
  - If only the outgoing owner still requests (case b), it is re-granted: grant stays high and hold_cnt restarts at 0.
  - If no requests, go to IDLE; grant=0, busy=0.
- Otherwise in OWN: hold_cnt increments, saturating at MAX_HOLD-1.
- Simultaneous requests: resolved purely by the ptr order. No requester is starved beyond 3*MAX_HOLD cycles.
- Datapath, every edge:
  - y <= d_in[sel slice] when the registered grant is active, else 0.
  - y_valid <= busy (previous cycle).
  - So y lags grant by one cycle; y_valid aligns with y.
- busy == |grant at all times. grant is always one-hot or zero; sel is valid only when busy=1 and holds its last value in IDLE.
- A req bit that drops while not granted is simply ignored; there is no latching of requests.
- Reset mid-grant: all outputs clear immediately (asynchronous), ptr returns to 0, and the in-flight y is discarded.

Test Plan:
- Reset with req=4'b1111 held -> outputs 0 during reset. First edge after release: grant=0001, sel=0. One cycle later: y=d0, y_valid=1.
- req=4'b0100 alone for 3 cycles then 0 (DATA_W=1, d_in=4'b1010) -> grant=0100 for 3 cycles, sel=2, y=0 one cycle later. Then grant=0, busy=0, y_valid drops one cycle after.
- req=1111 held, MAX_HOLD=8 -> grants rotate 0001,0010,0100,1000,0001, each for exactly 8 cycles, with no idle gaps.
- Requester 1 holds, requester 3 raises req at hold_cnt=2; requester 1 drops at cycle 5 -> grant switches 0010->1000 at the same edge; sel 1->3; y switches one cycle later.
- Only requester 0 requests for 20 cycles, MAX_HOLD=8 -> grant stays 0001 continuously; internal hold_cnt wraps at 8 and 16; busy never drops.
- rst_n pulsed low mid-grant (grant=0100) -> grant, y, y_valid go 0 without a clock. After release with req=1111: grant=0001 (ptr reset).
